// File: rtl/ahb_mem_slave_pkg.sv
// Shared types for the AHB memory slave: response codes, FSM states and byte-lane helper.
package ahb_mem_slave_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b01,
      RESP_RETRY = 2'b10,
      RESP_SPLIT = 2'b11
   } hresp_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_RESP1,
      ST_RESP2
   } state_t;

   // Byte-lane mask for an aligned transfer of 1<<size bytes starting at byte offset.
   function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
      logic [15:0] ones;
      ones = (16'd1 << (4'd1 << size)) - 16'd1;
      return ones[7:0] << offset;
   endfunction

endpackage

// File: rtl/ahb_split_tracker.sv
// Pending-split register per master and the one-cycle HSPLIT release pulse.
// Only compiled when AHB_MEM_SLAVE_SPLIT_EN is defined.
`ifdef AHB_MEM_SLAVE_SPLIT_EN
module ahb_split_tracker #(
   parameter int NUM_MASTERS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   set_en,
   input  logic [3:0]             set_master,
   input  logic                   release_all,
   output logic [NUM_MASTERS-1:0] hsplit
);

   logic [NUM_MASTERS-1:0] pending;
   logic [NUM_MASTERS-1:0] set_mask;

   assign set_mask = set_en ? (NUM_MASTERS'(1) << set_master) : '0;

   // A split recorded in the release cycle misses this pulse and waits for the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         hsplit  <= '0;
      end else if (release_all) begin
         hsplit  <= pending;
         pending <= set_mask;
      end else begin
         hsplit  <= '0;
         pending <= pending | set_mask;
      end
   end

endmodule
`endif

// File: rtl/ahb_mem_slave.sv
// AHB slave with a DEPTH-word RAM, injectable wait states and OKAY/ERROR/RETRY/SPLIT responses.
// Define AHB_MEM_SLAVE_SPLIT_EN for SPLIT support; otherwise SPLIT is answered as RETRY and HSPLIT is 0.
module ahb_mem_slave
   import ahb_mem_slave_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_W      = 3,
   parameter int NUM_MASTERS = 4
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic                   HSEL,
   input  logic                   HREADYIN,
   input  logic [ADDR_W-1:0]      HADDR,
   input  logic [1:0]             HTRANS,
   input  logic                   HWRITE,
   input  logic [2:0]             HSIZE,
   input  logic [2:0]             HBURST,
   input  logic [DATA_W-1:0]      HWDATA,
   input  logic [3:0]             HMASTER,
   input  logic                   HMASTLOCK,
   input  logic [1:0]             HRESP_i,
   input  logic [WAIT_W-1:0]      wait_cycle_i,
   input  logic                   deassert_split,
   output logic                   HREADY,
   output logic [1:0]             HRESP,
   output logic [DATA_W-1:0]      HRDATA,
   output logic [NUM_MASTERS-1:0] HSPLIT,
   output logic                   HMASTLOCK_o
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);

   state_t            state;
   hresp_t            code_q;
   hresp_t            acc_code;
   hresp_t            hresp_q;
   logic              hready_q;
   logic [IDX_W-1:0]  idx_q;
   logic [OFF_W-1:0]  off_q;
   logic [2:0]        size_q;
   logic              write_q;
   logic [WAIT_W-1:0] counter;
   logic [ADDR_W-1:0] word_idx;
   logic              accept;
   logic              force_err;
   logic [NB-1:0]     lane_en;
   logic [DATA_W-1:0] mem [DEPTH];

   assign accept   = HSEL & HREADYIN & HTRANS[1] & hready_q;
   assign word_idx = HADDR >> OFF_W;
   assign force_err = (word_idx >= ADDR_W'(DEPTH))
                    | ((HADDR[7:0] & ((8'd1 << HSIZE) - 8'd1)) != 8'd0)
                    | (HSIZE > 3'(OFF_W));

   always_comb begin
      // NOTE: acc_code gets a default first so every path assigns it and no latch is inferred.
      acc_code = hresp_t'(HRESP_i);
`ifdef AHB_MEM_SLAVE_SPLIT_EN
      if (acc_code == RESP_SPLIT && 32'(HMASTER) >= NUM_MASTERS) acc_code = RESP_ERROR;
`else
      if (acc_code == RESP_SPLIT) acc_code = RESP_RETRY;
`endif
      if (force_err) acc_code = RESP_ERROR;
   end

`ifdef AHB_MEM_SLAVE_SPLIT_EN
   logic [3:0] master_q;
`endif

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         hready_q <= 1'b1;
         hresp_q  <= RESP_OKAY;
         code_q   <= RESP_OKAY;
         counter  <= '0;
         idx_q    <= '0;
         off_q    <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
`ifdef AHB_MEM_SLAVE_SPLIT_EN
         master_q <= '0;
`endif
      end else begin
         case (state)
            ST_WAIT: begin
               if (counter > WAIT_W'(1)) begin
                  counter <= counter - WAIT_W'(1);
               end else begin
                  state    <= (code_q == RESP_OKAY) ? ST_DATA : ST_RESP1;
                  hready_q <= (code_q == RESP_OKAY);
                  hresp_q  <= code_q;
                  counter  <= '0;
               end
            end
            ST_RESP1: begin
               state    <= ST_RESP2;
               hready_q <= 1'b1;
            end
            default: begin
               if (accept) begin
                  idx_q   <= word_idx[IDX_W-1:0];
                  off_q   <= HADDR[OFF_W-1:0];
                  size_q  <= HSIZE;
                  write_q <= HWRITE;
                  code_q  <= acc_code;
                  counter <= wait_cycle_i;
`ifdef AHB_MEM_SLAVE_SPLIT_EN
                  master_q <= HMASTER;
`endif
                  if (wait_cycle_i != '0) begin
                     state    <= ST_WAIT;
                     hready_q <= 1'b0;
                     hresp_q  <= RESP_OKAY;
                  end else begin
                     state    <= (acc_code == RESP_OKAY) ? ST_DATA : ST_RESP1;
                     hready_q <= (acc_code == RESP_OKAY);
                     hresp_q  <= acc_code;
                  end
               end else begin
                  state    <= ST_IDLE;
                  hready_q <= 1'b1;
                  hresp_q  <= RESP_OKAY;
               end
            end
         endcase
      end
   end

   assign lane_en = NB'(lane_mask(size_q, 3'(off_q)));

   // NOTE: the RAM is deliberately not reset; contents survive HRESETn.
   always_ff @(posedge HCLK) begin
      if (state == ST_DATA && write_q) begin
         for (int b = 0; b < NB; b++) begin
            if (lane_en[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   // Asynchronous read so a read right after a write to the same word sees the new data.
   assign HRDATA      = (state == ST_DATA && !write_q) ? mem[idx_q] : '0;
   assign HREADY      = hready_q;
   assign HRESP       = hresp_q;
   assign HMASTLOCK_o = HMASTLOCK;

`ifdef AHB_MEM_SLAVE_SPLIT_EN
   ahb_split_tracker #(.NUM_MASTERS(NUM_MASTERS)) u_split (
      .clk         (HCLK),
      .rst_n       (HRESETn),
      .set_en      (state == ST_RESP1 && code_q == RESP_SPLIT),
      .set_master  (master_q),
      .release_all (deassert_split),
      .hsplit      (HSPLIT)
   );
   logic unused;
   assign unused = ^{HBURST, HTRANS[0]};
`else
   assign HSPLIT = '0;
   logic unused;
   assign unused = ^{HBURST, HTRANS[0], HMASTER, deassert_split};
`endif

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed, table-driven bench for ahb_mem_slave with hand-written multi-cycle sequences.
module tb_ahb_mem_slave;

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] ERR = 2'b01;
   localparam logic [1:0] RTY = 2'b10;
   localparam logic [1:0] SPL = 2'b11;
`ifdef AHB_MEM_SLAVE_SPLIT_EN
   localparam logic [1:0] SPLIT_EXP  = SPL;
   localparam logic [1:0] ILLEGAL_EXP = ERR;
   localparam logic [3:0] HSPLIT_EXP = 4'b0100;
`else
   localparam logic [1:0] SPLIT_EXP  = RTY;
   localparam logic [1:0] ILLEGAL_EXP = RTY;
   localparam logic [3:0] HSPLIT_EXP = 4'b0000;
`endif

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL, HREADYIN, HWRITE, HMASTLOCK, deassert_split;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS, HRESP_i, HRESP;
   logic [2:0]  HSIZE, HBURST, wait_cycle_i;
   logic [3:0]  HMASTER, HSPLIT;
   logic        HREADY, HMASTLOCK_o;

   ahb_mem_slave dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADYIN(HREADYIN), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
      .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK), .HRESP_i(HRESP_i), .wait_cycle_i(wait_cycle_i),
      .deassert_split(deassert_split), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
      .HSPLIT(HSPLIT), .HMASTLOCK_o(HMASTLOCK_o)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [2:0]  waitc;
      logic [1:0]  resp_i;
      logic [3:0]  master;
      int          lows;
      logic [1:0]  eresp;
      logic [31:0] erdata;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [2:0] waitc,
                               input logic [1:0] resp_i, input logic [3:0] master, input int lows,
                               input logic [1:0] eresp, input logic [31:0] erdata);
      vec_t v;
      v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.waitc = waitc;
      v.resp_i = resp_i; v.master = master; v.lows = lows; v.eresp = eresp; v.erdata = erdata;
      return v;
   endfunction

   task automatic drive_idle();
      HSEL = 1'b0; HREADYIN = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd2;
      wait_cycle_i = '0; HRESP_i = OK; HMASTER = '0;
   endtask

   task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [2:0] waitc, input logic [1:0] resp_i, input logic [3:0] master);
      HSEL = 1'b1; HREADYIN = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
      wait_cycle_i = waitc; HRESP_i = resp_i; HMASTER = master;
   endtask

   // Single transfer: address phase, then data phase until HREADY; returns what the bus saw.
   task automatic do_xfer(input vec_t v, output int lows, output logic [1:0] resp_low,
                          output logic [1:0] resp_end, output logic [31:0] rdata);
      addr_phase(v.wr, v.addr, v.size, v.waitc, v.resp_i, v.master);
      @(posedge HCLK); #1;
      drive_idle();
      HWDATA   = v.wdata;
      lows     = 0;
      resp_low = OK;
      while (HREADY !== 1'b1 && lows < 20) begin
         lows++;
         resp_low = HRESP;
         @(posedge HCLK); #1;
      end
      resp_end = HRESP;
      rdata    = HRDATA;
      @(posedge HCLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          lows;
      logic [1:0]  resp_low, resp_end;
      logic [31:0] rdata;

      vecs.push_back(mk(1, 32'h010, 2, 32'hA5A5A5A5, 0, OK,  0, 0, OK,  32'h0));
      vecs.push_back(mk(0, 32'h010, 2, 32'h0,        0, OK,  0, 0, OK,  32'hA5A5A5A5));
      vecs.push_back(mk(1, 32'h014, 2, 32'h11223344, 3, OK,  0, 3, OK,  32'h0));
      vecs.push_back(mk(0, 32'h014, 2, 32'h0,        0, OK,  0, 0, OK,  32'h11223344));
      vecs.push_back(mk(1, 32'h020, 2, 32'h00000055, 0, OK,  0, 0, OK,  32'h0));
      vecs.push_back(mk(1, 32'h020, 2, 32'h12345678, 0, ERR, 0, 1, ERR, 32'h0));
      vecs.push_back(mk(0, 32'h020, 2, 32'h0,        0, OK,  0, 0, OK,  32'h00000055));
      vecs.push_back(mk(1, 32'h000, 2, 32'h11111111, 0, OK,  0, 0, OK,  32'h0));
      vecs.push_back(mk(1, 32'h002, 1, 32'hBEEF0000, 0, OK,  0, 0, OK,  32'h0));
      vecs.push_back(mk(0, 32'h000, 2, 32'h0,        0, OK,  0, 0, OK,  32'hBEEF1111));
      vecs.push_back(mk(1, 32'h001, 0, 32'h0000CC00, 0, OK,  0, 0, OK,  32'h0));
      vecs.push_back(mk(0, 32'h000, 2, 32'h0,        0, OK,  0, 0, OK,  32'hBEEFCC11));
      vecs.push_back(mk(1, 32'h001, 1, 32'hFFFFFFFF, 0, OK,  0, 1, ERR, 32'h0));
      vecs.push_back(mk(0, 32'h001, 2, 32'h0,        0, OK,  0, 1, ERR, 32'h0));
      vecs.push_back(mk(1, 32'h3FC, 2, 32'hCAFEF00D, 0, OK,  0, 0, OK,  32'h0));
      vecs.push_back(mk(0, 32'h3FC, 2, 32'h0,        0, OK,  0, 0, OK,  32'hCAFEF00D));
      vecs.push_back(mk(1, 32'h400, 2, 32'hDEADDEAD, 0, OK,  0, 1, ERR, 32'h0));
      vecs.push_back(mk(0, 32'h000, 2, 32'h0,        0, OK,  0, 0, OK,  32'hBEEFCC11));
      vecs.push_back(mk(0, 32'h008, 3, 32'h0,        0, OK,  0, 1, ERR, 32'h0));
      vecs.push_back(mk(0, 32'h010, 2, 32'h0,        0, RTY, 0, 1, RTY, 32'h0));
      vecs.push_back(mk(0, 32'h010, 2, 32'h0,        2, ERR, 0, 3, ERR, 32'h0));
      vecs.push_back(mk(0, 32'h014, 2, 32'h0,        1, OK,  0, 1, OK,  32'h11223344));
      vecs.push_back(mk(0, 32'h010, 2, 32'h0,        0, SPL, 5, 1, ILLEGAL_EXP, 32'h0));
      vecs.push_back(mk(0, 32'h010, 2, 32'h0,        0, SPL, 2, 1, SPLIT_EXP,   32'h0));

      HRESETn = 1'b0; HMASTLOCK = 1'b0; HBURST = 3'b000; HWDATA = '0; deassert_split = 1'b0;
      drive_idle();
      #12;
      check("reset HREADY", HREADY, 1'b1);
      check("reset HRESP",  HRESP,  OK);
      check("reset HRDATA", HRDATA, 32'h0);
      check("reset HSPLIT", HSPLIT, 4'h0);
      @(negedge HCLK) HRESETn = 1'b1;
      @(posedge HCLK); #1;

      foreach (vecs[i]) begin
         do_xfer(vecs[i], lows, resp_low, resp_end, rdata);
         check($sformatf("v%0d wait cycles", i), 64'(lows), 64'(vecs[i].lows));
         check($sformatf("v%0d HRESP", i), resp_end, vecs[i].eresp);
         check($sformatf("v%0d HRDATA", i), rdata, vecs[i].erdata);
         if (vecs[i].lows > 0) check($sformatf("v%0d HRESP while low", i), resp_low, vecs[i].eresp);
      end

      // Release pending splits: a one-cycle pulse, then nothing left pending.
      deassert_split = 1'b1;
      @(posedge HCLK); #1;
      deassert_split = 1'b0;
      check("split pulse", HSPLIT, HSPLIT_EXP);
      @(posedge HCLK); #1;
      check("split pulse ends", HSPLIT, 4'h0);
      deassert_split = 1'b1;
      @(posedge HCLK); #1;
      deassert_split = 1'b0;
      check("split pending cleared", HSPLIT, 4'h0);

      // Write then read the same word back to back: read data phase must see the new value.
      addr_phase(1'b1, 32'h030, 3'd2, 3'd0, OK, 4'd0);
      @(posedge HCLK); #1;
      HWDATA = 32'h0BADCAFE;
      addr_phase(1'b0, 32'h030, 3'd2, 3'd0, OK, 4'd0);
      @(posedge HCLK); #1;
      drive_idle();
      check("pipelined read HREADY", HREADY, 1'b1);
      check("pipelined read HRDATA", HRDATA, 32'h0BADCAFE);
      @(posedge HCLK); #1;

      // Address phases that must not be accepted: HREADYIN low, then BUSY.
      addr_phase(1'b1, 32'h010, 3'd2, 3'd2, OK, 4'd0);
      HREADYIN = 1'b0;
      @(posedge HCLK); #1;
      drive_idle();
      HWDATA = 32'hDEADBEEF;
      check("HREADYIN low ignored", HREADY, 1'b1);
      addr_phase(1'b1, 32'h010, 3'd2, 3'd2, OK, 4'd0);
      HTRANS = 2'b01;
      @(posedge HCLK); #1;
      drive_idle();
      check("BUSY ignored", HREADY, 1'b1);
      @(posedge HCLK); #1;
      do_xfer(mk(0, 32'h010, 2, 32'h0, 0, OK, 0, 0, OK, 32'h0), lows, resp_low, resp_end, rdata);
      check("no stray write", rdata, 32'hA5A5A5A5);

      // Asynchronous reset in the middle of a wait sequence.
      addr_phase(1'b0, 32'h014, 3'd2, 3'd5, OK, 4'd0);
      @(posedge HCLK); #1;
      drive_idle();
      check("wait entered", HREADY, 1'b0);
      @(posedge HCLK); #2;
      HRESETn = 1'b0;
      #1;
      check("reset in WAIT HREADY", HREADY, 1'b1);
      check("reset in WAIT HRESP",  HRESP,  OK);
      check("reset in WAIT HRDATA", HRDATA, 32'h0);
      check("reset in WAIT HSPLIT", HSPLIT, 4'h0);
      @(negedge HCLK) HRESETn = 1'b1;
      @(posedge HCLK); #1;
      do_xfer(mk(0, 32'h014, 2, 32'h0, 0, OK, 0, 0, OK, 32'h0), lows, resp_low, resp_end, rdata);
      check("after reset wait cycles", 64'(lows), 64'd0);
      check("after reset HRESP", resp_end, OK);
      check("after reset HRDATA", rdata, 32'h11223344);

      HMASTLOCK = 1'b1;
      #1 check("HMASTLOCK_o high", HMASTLOCK_o, 1'b1);
      HMASTLOCK = 1'b0;
      #1 check("HMASTLOCK_o low", HMASTLOCK_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
